// File: rtl/ldgm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ldgm_pkg
//  Description : Shared constants for the LDGM signature path: code geometry,
//                error-stream command codes and the collector state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package ldgm_pkg;

    localparam int N_COLS = 4900;
    localparam int IDX_W  = 13;

    // err_valid command codes from the signature generator
    localparam logic [1:0] ERR_IDLE  = 2'b00;
    localparam logic [1:0] ERR_VALID = 2'b01;
    localparam logic [1:0] ERR_CLEAR = 2'b10;
    localparam logic [1:0] ERR_ALL   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage : ldgm_pkg
`default_nettype wire

// File: rtl/err_cam.sv
`default_nettype none
// ============================================================================
//  Module      : err_cam
//  Description : MAX_W x IDX_W slot table holding the live error indices.
//                Slots 0..live_cnt-1 are live. Parallel compare of cmp_idx
//                against live slots gives hit/hit_slot. Insert writes cmp_idx
//                into slot[live_cnt]; remove back-fills rem_slot with the
//                last live slot. Combinational read port at rd_slot.
//  Ports       : clk, rst (async, active-high)
//                live_cnt, cmp_idx        -> hit, hit_slot
//                ins_en, rem_en, rem_slot  (table update)
//                rd_slot                  -> rd_data
//  Revision    : 1.0 - initial release
// ============================================================================
module err_cam #(
    parameter int MAX_W = 32,
    parameter int IDX_W = 13,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] live_cnt,
    input  logic [IDX_W-1:0] cmp_idx,
    output logic             hit,
    output logic [CNT_W-1:0] hit_slot,
    input  logic             ins_en,
    input  logic             rem_en,
    input  logic [CNT_W-1:0] rem_slot,
    input  logic [CNT_W-1:0] rd_slot,
    output logic [IDX_W-1:0] rd_data
);

    logic [IDX_W-1:0] r_slot [MAX_W];
    logic [MAX_W-1:0] w_match;
    logic [IDX_W-1:0] w_last;
    logic [CNT_W-1:0] w_last_slot;

    assign w_last_slot = live_cnt - 1'b1;

    // Table never holds duplicates, so at most one match bit is set.
    generate
        for (genvar i = 0; i < MAX_W; i++) begin : g_cmp
            assign w_match[i] = (CNT_W'(i) < live_cnt) && (r_slot[i] == cmp_idx);
        end
    endgenerate

    assign hit = |w_match;

    always_comb begin
        hit_slot = '0;
        w_last   = '0;
        rd_data  = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (w_match[i])                   hit_slot = CNT_W'(i);
            if (w_last_slot == CNT_W'(i))     w_last   = r_slot[i];
            if (rd_slot == CNT_W'(i))         rd_data  = r_slot[i];
        end
    end

    generate
        for (genvar i = 0; i < MAX_W; i++) begin : g_slot
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_slot[i] <= '0;
                end else if (ins_en && (live_cnt == CNT_W'(i))) begin
                    r_slot[i] <= cmp_idx;
                end else if (rem_en && (rem_slot == CNT_W'(i))) begin
                    // Removing the last live slot rewrites it with itself; harmless.
                    r_slot[i] <= w_last;
                end
            end
        end
    endgenerate

endmodule : err_cam
`default_nettype wire

// File: rtl/err_vec_collect.sv
`default_nettype none
// ============================================================================
//  Module      : err_vec_collect
//  Description : Collects the generator's error-index stream into a sparse
//                GF(2) error vector (repeat index cancels), then drains the
//                vector in slot order over a valid/ready port.
//  Ports       : clk, rst (async, active-high)
//                err_valid[1:0], err_idx      - generator stream
//                out_valid, out_ready, out_idx, out_last - drain port
//                weight, ovf, range_err, done - status
//  Revision    : 1.0 - initial release
// ============================================================================
module err_vec_collect #(
    parameter int N_COLS = ldgm_pkg::N_COLS,
    parameter int IDX_W  = ldgm_pkg::IDX_W,
    parameter int MAX_W  = 32,
    localparam int CNT_W = $clog2(MAX_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       err_valid,
    input  logic [IDX_W-1:0] err_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic [CNT_W-1:0] weight,
    output logic             ovf,
    output logic             range_err,
    output logic             done
);

    import ldgm_pkg::*;

    localparam logic [IDX_W:0]   c_N_COLS = (IDX_W + 1)'(N_COLS);
    localparam logic [CNT_W-1:0] c_MAX_W  = CNT_W'(MAX_W);

    state_t           r_state;
    logic [CNT_W-1:0] r_weight;
    logic [CNT_W-1:0] r_rd_ptr;
    logic             r_ovf;
    logic             r_range_err;
    logic             r_out_valid;
    logic [IDX_W-1:0] r_out_idx;
    logic             r_out_last;
    logic             r_done;

    logic             w_ins_cmd;
    logic             w_oor;
    logic             w_hit;
    logic [CNT_W-1:0] w_hit_slot;
    logic             w_ins_en;
    logic             w_rem_en;
    logic [CNT_W-1:0] w_nxt_ptr;
    logic [CNT_W-1:0] w_rd_slot;
    logic [IDX_W-1:0] w_rd_data;

    assign w_ins_cmd = (r_state == ST_COLLECT) && (err_valid == ERR_VALID);
    assign w_oor     = ({1'b0, err_idx} >= c_N_COLS);
    assign w_rem_en  = w_ins_cmd && !w_oor && w_hit;
    assign w_ins_en  = w_ins_cmd && !w_oor && !w_hit && (r_weight < c_MAX_W);
    assign w_nxt_ptr = r_rd_ptr + 1'b1;
    // Prefetch the next slot while draining; slot 0 otherwise, ready for drain start.
    assign w_rd_slot = (r_state == ST_DRAIN) ? w_nxt_ptr : '0;

    err_cam #(
        .MAX_W (MAX_W),
        .IDX_W (IDX_W),
        .CNT_W (CNT_W)
    ) u_cam (
        .clk      (clk),
        .rst      (rst),
        .live_cnt (r_weight),
        .cmp_idx  (err_idx),
        .hit      (w_hit),
        .hit_slot (w_hit_slot),
        .ins_en   (w_ins_en),
        .rem_en   (w_rem_en),
        .rem_slot (w_hit_slot),
        .rd_slot  (w_rd_slot),
        .rd_data  (w_rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_weight    <= '0;
            r_rd_ptr    <= '0;
            r_ovf       <= 1'b0;
            r_range_err <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    // ERR_ALL is the generator's resting code and is ignored here.
                    if (err_valid == ERR_CLEAR) begin
                        r_state     <= ST_COLLECT;
                        r_weight    <= '0;
                        r_ovf       <= 1'b0;
                        r_range_err <= 1'b0;
                    end
                end
                ST_COLLECT: begin
                    unique case (err_valid)
                        ERR_CLEAR: begin
                            r_weight    <= '0;
                            r_ovf       <= 1'b0;
                            r_range_err <= 1'b0;
                        end
                        ERR_VALID: begin
                            if (w_oor)         r_range_err <= 1'b1;
                            else if (w_rem_en) r_weight    <= r_weight - 1'b1;
                            else if (w_ins_en) r_weight    <= r_weight + 1'b1;
                            else               r_ovf       <= 1'b1;
                        end
                        ERR_ALL: begin
                            if (r_weight != '0) begin
                                r_state     <= ST_DRAIN;
                                r_rd_ptr    <= '0;
                                r_out_valid <= 1'b1;
                                r_out_idx   <= w_rd_data;
                                r_out_last  <= (r_weight == CNT_W'(1));
                            end else begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                ST_DRAIN: begin
                    if (r_out_valid && out_ready) begin
                        if (r_out_last) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_out_idx   <= '0;
                            r_state     <= ST_DONE;
                            r_done      <= 1'b1;
                        end else begin
                            r_rd_ptr   <= w_nxt_ptr;
                            r_out_idx  <= w_rd_data;
                            r_out_last <= (w_nxt_ptr == (r_weight - 1'b1));
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_idx   = r_out_idx;
    assign out_last  = r_out_last;
    assign weight    = r_weight;
    assign ovf       = r_ovf;
    assign range_err = r_range_err;
    assign done      = r_done;

endmodule : err_vec_collect
`default_nettype wire
